hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the operand forwarding logic.
- Records, per architectural register, how many cycles remain until an in-flight write result becomes forwardable.
- Stalls the ID stage when a source operand, a WAW destination, or the non-pipelined multiplier is not yet available.
- Sits beside the ID/EX buffer; its stall output freezes the PC and IF/ID and inserts a bubble into ID/EX.

Parameters:
- NUM_REGS, 16, architectural registers; addresses are log2 = 4 bits; R0 is never tracked.
- LAT_LOAD, 2, issue-to-forwardable distance for loads.
- LAT_MUL, 4, issue-to-forwardable distance for multiply; also the multiplier occupancy.
- CNT_W, 3, counter width; must hold LAT_MUL-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1  in  4  source register 1 address
- id_rs1_used  in  1  rs1 is read
- id_rs2  in  4  source register 2 address
- id_rs2_used  in  1  rs2 is read
- id_rd  in  4  destination register address
- id_we  in  1  instruction writes rd
- id_class  in  2  latency class: 00 ALU, 01 LOAD, 10 MUL, 11 reserved (treated as ALU)
- flush  in  1  branch taken; the ID instruction is killed this cycle
- stall  out  1  hold IF/ID and PC, bubble into ID/EX (combinational)
- issue  out  1  the ID instruction advances this cycle (combinational)
- pending  out  16  bit r = cnt[r] != 0 (registered state)
- stall_cycles  out  16  saturating count of stalled cycles

Behaviour:
- State:
  - cnt[1..15], CNT_W bits each; cnt[0] is constant 0.
  - mul_busy counter, CNT_W bits.
  - stall_cycles.
- Reset (rst_n==0 at a clk edge): all cnt=0, mul_busy=0, stall_cycles=0. Therefore stall=0 whenever id_valid=0, pending=0, stall_cycles=0.
- Reset applied mid-operation discards all in-flight tracking with no residue on the following cycle.
- Latency L per class: ALU=1, LOAD=LAT_LOAD, MUL=LAT_MUL.
- raw_stall = id_valid & any of:
  - id_rs1_used & cnt[id_rs1]!=0
  - id_rs2_used & cnt[id_rs2]!=0
  - id_we & id_rd!=0 & cnt[id_rd] > L-1 (WAW: an older write would land after the newer one)
  - id_class==MUL & mul_busy!=0
- stall = raw_stall & ~flush. Flush overrides stall so the killed instruction drains.
- issue = id_valid & ~stall & ~flush.
- Per cycle, for each register r:
  - If issue & id_we & id_rd==r & r!=0: cnt[r] <= L-1. Issue wins over decrement.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- mul_busy:
  - On issue of a MUL: mul_busy <= LAT_MUL-1.
  - Else decrement toward 0.
  - A MUL with id_we=0 still occupies the multiplier.
- Stalled or flushed instructions never update any counter.
- An address of 0 in rs1, rs2, or rd never causes a stall and never sets a counter.
- Resulting stall cycles for a dependent instruction placed immediately after its producer: ALU 0, LOAD 1, MUL 3. Each intervening instruction reduces this by 1, floored at 0.
- stall_cycles increments when stall=1 and holds at 16'hFFFF.
- pending is derived directly from the cnt registers and carries no additional latency.

Decomposition:
- Shared package cpu_pkg holds:
  - Class encodings CLS_ALU, CLS_LOAD, CLS_MUL.
  - NUM_REGS and register address width.
  - Latency constants.
- Sub-module reg_ready_ctr: one CNT_W countdown with load and decrement, load priority. Generated NUM_REGS-1 times plus once for mul_busy.
- Stall and issue logic remains in the top level.

Test Plan:
- LOAD R3 (class 01, rd=3) issued; next cycle an ADD reads rs1=3 -> stall=1 for exactly 1 cycle; pending[3]=1 in that cycle; issue=1 on the following cycle; stall_cycles=1.
- MUL R5 issued, then an ADD reading rs2=5 -> stall high for 3 consecutive cycles; pending[5] is high for 3 cycles after the MUL issue; stall_cycles=3.
- MUL R5 followed immediately by MUL R6 (independent) -> structural stall for 3 cycles; the second MUL issues once mul_busy=0; cnt[6] loads 3.
- MUL R4 followed by ALU writing R4 (WAW, cnt[4]=3 > 0) -> stall 3 cycles. LOAD R4 followed by ALU writing R4 -> stall 1 cycle.
- LOAD R0, then a reader of rs1=0 -> stall=0 and pending=0. A stall condition on a cycle with flush=1 -> stall=0, issue=0, no counter load.
- MUL R7 issued, then rst_n=0 for 1 cycle at the next edge -> pending=0 and mul_busy=0; a subsequent reader of R7 has stall=0. Saturation check: hold a stall condition for 70000 cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry, latency classes and their
// issue-to-forwardable distances.
package cpu_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_RSVD = 2'b11
  } cls_e;

  // Countdown value loaded on issue (L-1); reserved class behaves as ALU.
  function automatic logic [CNT_W-1:0] cls_lat_m1(cls_e c);
    case (c)
      CLS_LOAD: cls_lat_m1 = CNT_W'(LAT_LOAD - 1);
      CLS_MUL:  cls_lat_m1 = CNT_W'(LAT_MUL - 1);
      default:  cls_lat_m1 = '0;
    endcase
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: decoded operands in, stall/issue/status out.
interface hazard_scoreboard_if;
  import cpu_pkg::*;
  logic                id_valid;
  logic [REG_AW-1:0]   id_rs1;
  logic                id_rs1_used;
  logic [REG_AW-1:0]   id_rs2;
  logic                id_rs2_used;
  logic [REG_AW-1:0]   id_rd;
  logic                id_we;
  logic [1:0]          id_class;
  logic                flush;
  logic                stall;
  logic                issue;
  logic [NUM_REGS-1:0] pending;
  logic [15:0]         stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_we,
           id_class, flush,
    input  stall, issue, pending, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_we,
           id_class, flush,
    output stall, issue, pending, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_reg_ready_ctr.sv
// Countdown to forwardable: load has priority over decrement, parks at zero.
module reg_ready_ctr
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register write-latency scoreboard; stalls ID on RAW, WAW and busy multiplier.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  hazard_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]               mul_cnt;
  logic [CNT_W-1:0]               lat_m1;
  cls_e                           cls;
  logic                           is_mul;
  logic                           rd_nz;
  logic                           raw_stall;
  logic [15:0]                    stall_ctr;

  assign cls    = cls_e'(sb.id_class);
  assign is_mul = (cls == CLS_MUL);
  assign lat_m1 = cls_lat_m1(cls);
  assign rd_nz  = (sb.id_rd != '0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_r0
      assign cnt[r] = '0;
    end else begin : g_ctr
      reg_ready_ctr u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sb.issue & sb.id_we & (sb.id_rd == REG_AW'(r))),
        .load_val (lat_m1),
        .cnt      (cnt[r])
      );
    end
    assign sb.pending[r] = (cnt[r] != '0);
  end

  // A MUL occupies the multiplier whether or not it writes rd.
  reg_ready_ctr u_mul_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sb.issue & is_mul),
    .load_val (CNT_W'(LAT_MUL - 1)),
    .cnt      (mul_cnt)
  );

  // WAW: an older write still landing after this one would clobber it.
  always_comb begin
    raw_stall = 1'b0;
    if (sb.id_valid) begin
      raw_stall = (sb.id_rs1_used & (cnt[sb.id_rs1] != '0))
                | (sb.id_rs2_used & (cnt[sb.id_rs2] != '0))
                | (sb.id_we & rd_nz & (cnt[sb.id_rd] > lat_m1))
                | (is_mul & (mul_cnt != '0));
    end
  end

  assign sb.stall = raw_stall & ~sb.flush;
  assign sb.issue = sb.id_valid & ~sb.stall & ~sb.flush;

  always_ff @(posedge clk) begin
    if (!rst_n)                                 stall_ctr <= '0;
    else if (sb.stall && stall_ctr != 16'hFFFF) stall_ctr <= stall_ctr + 16'd1;
  end
  assign sb.stall_cycles = stall_ctr;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a reference model predicts each cycle's outputs into a
// queue; entries are popped and compared at the negedge.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if sb();
  hazard_scoreboard dut (.clk(clk), .rst_n(rst_n), .sb(sb));

  typedef struct {
    logic        stall;
    logic        issue;
    logic [15:0] pend;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   mcnt[16];
  int   mbusy, msc;
  int   n_chk = 0, n_err = 0;
  bit   chk_en = 1'b1;
  bit   last_iss;
  bit   dut_stall_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    sb.id_valid = 1'b0;
    sb.flush    = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (mcnt[r]) mcnt[r] = 0;
    mbusy = 0;
    msc   = 0;
  endtask

  task automatic cyc(input logic v, input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                     input logic we, input logic [1:0] cls, input logic fl);
    exp_t e, g;
    int   lat;
    logic raw;
    sb.id_valid = v;  sb.id_rs1 = rs1; sb.id_rs1_used = u1;
    sb.id_rs2 = rs2;  sb.id_rs2_used = u2; sb.id_rd = rd;
    sb.id_we = we;    sb.id_class = cls;   sb.flush = fl;
    lat = (cls == 2'b10) ? 4 : (cls == 2'b01) ? 2 : 1;
    raw = v && ((u1 && mcnt[rs1] != 0) || (u2 && mcnt[rs2] != 0) ||
                (we && rd != 0 && mcnt[rd] > lat - 1) || (cls == 2'b10 && mbusy != 0));
    e.stall = raw && !fl;
    e.issue = v && !e.stall && !fl;
    for (int r = 0; r < 16; r++) e.pend[r] = (mcnt[r] != 0);
    e.sc = msc[15:0];
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    dut_stall_seen = (sb.stall === 1'b1);
    if (chk_en) begin
      chk("stall", 32'(sb.stall), 32'(g.stall));
      chk("issue", 32'(sb.issue), 32'(g.issue));
      chk("pending", 32'(sb.pending), 32'(g.pend));
      chk("stall_cycles", 32'(sb.stall_cycles), 32'(g.sc));
    end
    last_iss = g.issue;
    @(posedge clk);
    for (int r = 1; r < 16; r++) begin
      if (g.issue && we && rd == 4'(r)) mcnt[r] = lat - 1;
      else if (mcnt[r] > 0)             mcnt[r]--;
    end
    if (g.issue && cls == 2'b10) mbusy = 3;
    else if (mbusy > 0)          mbusy--;
    if (g.stall && msc != 16'hFFFF) msc++;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
  endtask

  // Hold an instruction in ID until it issues; returns DUT-observed stall count.
  task automatic issue_op(input logic [1:0] cls, input logic [3:0] rd, input logic we,
                          input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2, output int nst);
    bit done = 1'b0;
    nst = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      cyc(1'b1, rs1, u1, rs2, u2, rd, we, cls, 1'b0);
      if (dut_stall_seen) nst++;
      if (last_iss) done = 1'b1;
    end
    if (!done) chk("issue_bound", 32'd0, 32'd1);
  endtask

  int ns;

  initial begin
    sb.id_valid = 1'b0; sb.id_rs1 = '0; sb.id_rs1_used = 1'b0;
    sb.id_rs2 = '0; sb.id_rs2_used = 1'b0; sb.id_rd = '0;
    sb.id_we = 1'b0; sb.id_class = '0; sb.flush = 1'b0;
    do_reset();
    idle();
    chk("rst_pending", 32'(sb.pending), 32'd0);
    chk("rst_sc", 32'(sb.stall_cycles), 32'd0);

    // LOAD -> dependent ADD
    issue_op(2'b01, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, ns);
    chk("load_raw_stalls", 32'(ns), 32'd1);
    idle();
    chk("load_raw_sc", 32'(sb.stall_cycles), 32'd1);

    // MUL -> dependent ADD via rs2
    do_reset();
    issue_op(2'b10, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, ns);
    chk("mul_raw_stalls", 32'(ns), 32'd3);
    idle();
    chk("mul_raw_sc", 32'(sb.stall_cycles), 32'd3);

    // Back-to-back independent MULs: structural hazard
    do_reset();
    issue_op(2'b10, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b10, 4'd6, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, ns);
    chk("mul_struct_stalls", 32'(ns), 32'd3);
    idle(); idle(); idle(); idle();

    // WAW after MUL and after LOAD
    do_reset();
    issue_op(2'b10, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    chk("waw_mul_stalls", 32'(ns), 32'd3);
    do_reset();
    issue_op(2'b01, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    chk("waw_load_stalls", 32'(ns), 32'd1);

    // Intervening instructions shorten the stall
    do_reset();
    issue_op(2'b01, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, ns);
    chk("load_gap_stalls", 32'(ns), 32'd0);
    issue_op(2'b10, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue_op(2'b00, 4'd1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, ns);
    chk("mul_gap_stalls", 32'(ns), 32'd2);

    // R0 is never tracked
    do_reset();
    issue_op(2'b01, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    chk("r0_pending", 32'(sb.pending), 32'd0);
    issue_op(2'b00, 4'd1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, ns);
    chk("r0_stalls", 32'(ns), 32'd0);

    // Flush overrides stall and suppresses counter loads
    do_reset();
    issue_op(2'b10, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    cyc(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 2'b00, 1'b1);
    chk("flush_stall", 32'(dut_stall_seen), 32'd0);
    do_reset();
    cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 2'b01, 1'b1);
    cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 2'b10, 1'b1);
    issue_op(2'b10, 4'd1, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0, ns);
    chk("flush_noload_stalls", 32'(ns), 32'd0);

    // Mid-operation reset leaves no residue
    do_reset();
    issue_op(2'b10, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    do_reset();
    chk("midrst_pending", 32'(sb.pending), 32'd0);
    issue_op(2'b10, 4'd1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, ns);
    chk("midrst_stalls", 32'(ns), 32'd0);

    // Saturation: chain of dependent MULs, 3 stalls each
    do_reset();
    chk_en = 1'b0;
    issue_op(2'b10, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    for (int i = 0; i < 21846; i++) begin
      if (i % 2 == 0) issue_op(2'b10, 4'd2, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, ns);
      else            issue_op(2'b10, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, ns);
    end
    chk_en = 1'b1;
    idle();
    chk("sat_sc", 32'(sb.stall_cycles), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
